multdiv_sequencer: RTL

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - sequences one multicycle mul/div from DX through the multdiv unit to writeback
//
// Ports:
//   clock, reset                 master clock; synchronous active-high reset
//   dx_valid, dx_ir              DX instruction and its liveness (0 = bubble)
//   dx_a, dx_b                   bypassed operand values for the DX instruction
//   flush                        squash an in-flight op (taken branch/jump)
//   md_result, md_exception      multdiv result and exception, qualified by md_ready
//   md_ready                     multdiv result ready
//   md_ctrl_mult, md_ctrl_div    one-cycle start pulses to multdiv
//   md_operand_a, md_operand_b   operands latched at accept, held until the next accept
//   stall                        freeze PC/FD/DX and bubble XM while an op is outstanding
//   wb_valid, wb_reg, wb_data    one-cycle writeback request
//   busy                         sequencer is not idle
module multdiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int unsigned RSTATUS = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_valid,
  input  logic [31:0] dx_ir,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam logic [5:0] LAST_CNT   = 6'(TIMEOUT - 1);
  localparam logic [4:0] STATUS_REG = 5'(RSTATUS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [4:0]  rd_q;
  logic        op_div_q;

  logic        dx_is_mul, dx_is_div;
  logic        accept, accept_mul, accept_div;
  logic        ready_ok, timeout_hit, finish;
  logic        fin_exc;
  logic        fin_valid;
  logic [4:0]  fin_reg;
  logic [31:0] fin_data;

  // Instruction fields that play no part in the decode.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{dx_ir[21:7], dx_ir[1:0]};

  assign dx_is_mul = dx_valid && (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == 5'b00110);
  assign dx_is_div = dx_valid && (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == 5'b00111);

  // A result seen in the very first BUSY cycle is left over from the previous op.
  assign ready_ok    = md_ready && (cnt_q != 6'd0);
  assign timeout_hit = (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    accept     = 1'b0;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    finish     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((dx_is_mul || dx_is_div) && !flush) begin
          accept     = 1'b1;
          accept_mul = dx_is_mul;
          accept_div = dx_is_div;
          stall      = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (ready_ok || timeout_hit) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The DONE instruction is older than anything that could flush it.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (reset) begin
      stall = 1'b0;
    end
  end

  // Writeback value chosen at the BUSY->DONE transition; a timeout counts as an exception.
  always_comb begin
    fin_exc   = ready_ok ? md_exception : 1'b1;
    fin_valid = 1'b0;
    fin_reg   = rd_q;
    fin_data  = md_result;
    if (fin_exc) begin
      fin_valid = 1'b1;
      fin_reg   = STATUS_REG;
      fin_data  = op_div_q ? 32'd5 : 32'd4;
    end else begin
      fin_valid = (rd_q != 5'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 6'd0;
      rd_q         <= 5'd0;
      op_div_q     <= 1'b0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      md_operand_a <= 32'd0;
      md_operand_b <= 32'd0;
      wb_valid     <= 1'b0;
      wb_reg       <= 5'd0;
      wb_data      <= 32'd0;
    end else begin
      state_q      <= state_d;
      md_ctrl_mult <= accept_mul;
      md_ctrl_div  <= accept_div;
      if (accept) begin
        md_operand_a <= dx_a;
        md_operand_b <= dx_b;
        rd_q         <= dx_ir[26:22];
        op_div_q     <= dx_is_div;
      end
      // Counter only runs while staying in BUSY, so it is zero on every BUSY entry.
      if ((state_q == S_BUSY) && (state_d == S_BUSY)) begin
        cnt_q <= cnt_q + 6'd1;
      end else begin
        cnt_q <= 6'd0;
      end
      wb_valid <= 1'b0;
      if (finish) begin
        wb_valid <= fin_valid;
        wb_reg   <= fin_reg;
        wb_data  <= fin_data;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule
